// File: rtl/id_ex_hazard_ctrl_if.sv
// Hazard-control bundle between the ID-stage datapath (master) and id_ex_hazard_ctrl (slave).
interface id_ex_hazard_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic              id_uses_rt;
  logic              ex_mem_read;
  logic [ADDR_W-1:0] ex_rt_addr;
  logic              branch_taken;
  logic              jump_reg;

  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              state;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_read, ex_rt_addr,
           branch_taken, jump_reg,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, state,
           stall_count, flush_count
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_read, ex_rt_addr,
           branch_taken, jump_reg,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, state,
           stall_count, flush_count
  );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// Load-use stall and branch/jr redirect flush control for the ID/EX register and front end.
// Optional HAZARD_PERF_EN builds saturating stall/redirect counters; otherwise they read 0.
module id_ex_hazard_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  id_ex_hazard_ctrl_if.slave  hz
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0]     RELOAD   = CW'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          lu;
  logic          redir;

  // Register 0 is hardwired, so a load "into" it never creates a dependency.
  assign lu = hz.ex_mem_read && (hz.ex_rt_addr != ZERO_REG) &&
              ((hz.ex_rt_addr == hz.id_rs_addr) ||
               (hz.id_uses_rt && (hz.ex_rt_addr == hz.id_rt_addr)));
  assign redir = hz.branch_taken | hz.jump_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (redir) begin
      if (FLUSH_CYCLES > 1) begin
        state_q <= FLUSH;
        cnt_q   <= RELOAD;
      end else begin
        state_q <= RUN;
        cnt_q   <= '0;
      end
    end else if (state_q == FLUSH) begin
      if (cnt_q <= CW'(1)) begin
        state_q <= RUN;
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q - CW'(1);
      end
    end
  end

  always_comb begin
    hz.pc_write    = 1'b1;
    hz.if_id_write = 1'b1;
    hz.if_id_flush = 1'b0;
    hz.id_ex_flush = 1'b0;
    if (rst) begin
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (redir || (state_q == FLUSH)) begin
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (lu) begin
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
      hz.id_ex_flush = 1'b1;
    end
  end

  assign hz.state = (state_q == FLUSH);

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             stall_apply;

  assign stall_apply = lu && !redir && (state_q == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_apply && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + CNT_W'(1);
      if (redir && (flush_q != {CNT_W{1'b1}}))       flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.stall_count = stall_q;
  assign hz.flush_count = flush_q;
`else
  assign hz.stall_count = {CNT_W{1'b0}};
  assign hz.flush_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench for id_ex_hazard_ctrl (FLUSH_CYCLES=2); ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush}.
module tb_id_ex_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  id_ex_hazard_ctrl_if #(.ADDR_W(5), .CNT_W(16)) ifc ();

  id_ex_hazard_ctrl #(.ADDR_W(5), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (ifc)
  );

  logic [3:0] ctl;
  assign ctl = {ifc.pc_write, ifc.if_id_write, ifc.if_id_flush, ifc.id_ex_flush};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.id_rs_addr   = 5'd0;
    ifc.id_rt_addr   = 5'd0;
    ifc.id_uses_rt   = 1'b0;
    ifc.ex_mem_read  = 1'b0;
    ifc.ex_rt_addr   = 5'd0;
    ifc.branch_taken = 1'b0;
    ifc.jump_reg     = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++;
    if (ctl !== 4'b0011) $display("FAIL reset_ctl: got %b want 0011", ctl); else pass_cnt++;
    total_cnt++;
    if (ifc.state !== 1'b0) $display("FAIL reset_state: got %b want 0", ifc.state); else pass_cnt++;
    total_cnt++;
    if (ifc.stall_count !== 16'd0 || ifc.flush_count !== 16'd0)
      $display("FAIL reset_counts: got %0d/%0d want 0/0", ifc.stall_count, ifc.flush_count);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    #2;
    total_cnt++;
    if (ctl !== 4'b1100) $display("FAIL reset_release_ctl: got %b want 1100", ctl); else pass_cnt++;
  endtask

  task automatic test_load_use();
    ifc.ex_mem_read = 1'b1;
    ifc.ex_rt_addr  = 5'd8;
    ifc.id_rs_addr  = 5'd8;
    #2;
    total_cnt++;
    if (ctl !== 4'b0001) $display("FAIL lu_rs_stall: got %b want 0001", ctl); else pass_cnt++;
    tick();
    ifc.ex_mem_read = 1'b0;
    #2;
    total_cnt++;
    if (ctl !== 4'b1100) $display("FAIL lu_after_bubble: got %b want 1100", ctl); else pass_cnt++;
    tick();
    ifc.ex_mem_read = 1'b1;
    ifc.ex_rt_addr  = 5'd9;
    ifc.id_rs_addr  = 5'd3;
    ifc.id_rt_addr  = 5'd9;
    ifc.id_uses_rt  = 1'b1;
    #2;
    total_cnt++;
    if (ctl !== 4'b0001) $display("FAIL lu_rt_stall: got %b want 0001", ctl); else pass_cnt++;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_no_false_stall();
    ifc.ex_mem_read = 1'b1;
    ifc.ex_rt_addr  = 5'd0;
    ifc.id_rs_addr  = 5'd0;
    #2;
    total_cnt++;
    if (ctl !== 4'b1100) $display("FAIL nostall_r0: got %b want 1100", ctl); else pass_cnt++;
    ifc.ex_rt_addr  = 5'd9;
    ifc.id_rt_addr  = 5'd9;
    ifc.id_rs_addr  = 5'd3;
    ifc.id_uses_rt  = 1'b0;
    #2;
    total_cnt++;
    if (ctl !== 4'b1100) $display("FAIL nostall_rt_unused: got %b want 1100", ctl); else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  task automatic test_branch();
    ifc.ex_mem_read  = 1'b1;
    ifc.ex_rt_addr   = 5'd8;
    ifc.id_rs_addr   = 5'd8;
    ifc.branch_taken = 1'b1;
    #2;
    total_cnt++;
    if (ctl !== 4'b1111 || ifc.state !== 1'b0)
      $display("FAIL br_cycle0: got ctl=%b st=%b want ctl=1111 st=0", ctl, ifc.state);
    else pass_cnt++;
    tick();
    ifc.branch_taken = 1'b0;
    #2;
    total_cnt++;
    if (ctl !== 4'b1111 || ifc.state !== 1'b1)
      $display("FAIL br_cycle1: got ctl=%b st=%b want ctl=1111 st=1", ctl, ifc.state);
    else pass_cnt++;
    tick();
    ifc.ex_mem_read = 1'b0;
    #2;
    total_cnt++;
    if (ctl !== 4'b1100 || ifc.state !== 1'b0)
      $display("FAIL br_cycle2: got ctl=%b st=%b want ctl=1100 st=0", ctl, ifc.state);
    else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  task automatic test_restart();
    ifc.jump_reg = 1'b1;
    tick();
    #2;
    total_cnt++;
    if (ctl !== 4'b1111 || ifc.state !== 1'b1)
      $display("FAIL rs_jr_in_flush: got ctl=%b st=%b want ctl=1111 st=1", ctl, ifc.state);
    else pass_cnt++;
    tick();
    ifc.jump_reg = 1'b0;
    #2;
    total_cnt++;
    if (ctl !== 4'b1111 || ifc.state !== 1'b1)
      $display("FAIL rs_extended: got ctl=%b st=%b want ctl=1111 st=1", ctl, ifc.state);
    else pass_cnt++;
    tick();
    #2;
    total_cnt++;
    if (ctl !== 4'b1100 || ifc.state !== 1'b0)
      $display("FAIL rs_done: got ctl=%b st=%b want ctl=1100 st=0", ctl, ifc.state);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_flush();
    ifc.branch_taken = 1'b1;
    tick();
    ifc.branch_taken = 1'b0;
    #1;
    total_cnt++;
    if (ifc.state !== 1'b1) $display("FAIL rmf_in_flush: got %b want 1", ifc.state); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (ctl !== 4'b0011 || ifc.state !== 1'b0)
      $display("FAIL rmf_forced: got ctl=%b st=%b want ctl=0011 st=0", ctl, ifc.state);
    else pass_cnt++;
    #2;
    rst = 1'b0;
    tick();
    #2;
    total_cnt++;
    if (ctl !== 4'b1100 || ifc.state !== 1'b0)
      $display("FAIL rmf_release: got ctl=%b st=%b want ctl=1100 st=0", ctl, ifc.state);
    else pass_cnt++;
  endtask

  task automatic test_perf();
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;
`ifdef HAZARD_PERF_EN
    exp_stall = 16'd3;
    exp_flush = 16'd2;
`else
    exp_stall = 16'd0;
    exp_flush = 16'd0;
`endif
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      ifc.ex_mem_read = 1'b1;
      ifc.ex_rt_addr  = 5'(i + 4);
      ifc.id_rs_addr  = 5'(i + 4);
      tick();
      ifc.ex_mem_read = 1'b0;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      ifc.branch_taken = (i == 0);
      ifc.jump_reg     = (i == 1);
      tick();
      idle_inputs();
      tick();
      tick();
    end
    #2;
    total_cnt++;
    if (ifc.stall_count !== exp_stall)
      $display("FAIL perf_stall: got %0d want %0d", ifc.stall_count, exp_stall);
    else pass_cnt++;
    total_cnt++;
    if (ifc.flush_count !== exp_flush)
      $display("FAIL perf_flush: got %0d want %0d", ifc.flush_count, exp_flush);
    else pass_cnt++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch();
    test_restart();
    test_reset_mid_flush();
    test_perf();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
